uart_rx_deserializer: RTL and testbench

- Receive-side stage that consumes the serial TX_OUT stream produced by the UART TX and recovers the parallel byte.
- Frame format matches the TX: idle-high line, start bit 0, DATA_WIDTH data bits LSB first, optional parity bit (PAR_EN; PAR_TYP 0=even, 1=odd), one stop bit 1.
- Oversamples each bit PRESCALE clocks and flags parity and stop errors.
- Used in loopback against the TX and as the reference receiver in the TX environment.

---
 rtl/uart_rx_deserializer.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: oversamples the serial line PRESCALE clocks per bit, recovers
// DATA_WIDTH data bits LSB first, and checks the optional parity bit and the stop bit.
module uart_rx_deserializer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA_OUT,
    output logic                  DATA_VALID_OUT,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic                  RX_BUSY
);

    localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntW-1:0] SampleCnt = CntW'(PRESCALE / 2);
    localparam logic [CntW-1:0] LastCnt   = CntW'(PRESCALE - 1);
    localparam logic [BitW-1:0] LastBit   = BitW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [BitW-1:0]       bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_bad_q, par_bad_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  serr_q, serr_d;
    logic                  sample, wrap;
    logic [CntW-1:0]       cnt_step;

    assign sample   = (cnt_q == SampleCnt);
    assign wrap     = (cnt_q == LastCnt);
    assign cnt_step = wrap ? '0 : cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        par_bad_d = par_bad_q;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        serr_d    = 1'b0;

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!RX_IN) begin
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    par_bad_d = 1'b0;
                    bit_d     = '0;
                    // At one clock per bit the detection edge is also the start-bit sample.
                    if (PRESCALE == 1) begin
                        state_d = StData;
                    end else begin
                        state_d = StStart;
                        cnt_d   = CntW'(1);
                    end
                end
            end
            StStart: begin
                cnt_d = cnt_step;
                if (sample && RX_IN) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (wrap) begin
                    state_d = StData;
                end
            end
            StData: begin
                cnt_d = cnt_step;
                if (sample) begin
                    shift_d = DATA_WIDTH'({RX_IN, shift_q} >> 1);
                end
                if (wrap) begin
                    if (bit_q == LastBit) begin
                        bit_d   = '0;
                        state_d = par_en_q ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            StParity: begin
                cnt_d = cnt_step;
                if (sample) begin
                    par_bad_d = RX_IN ^ (^shift_q) ^ par_typ_q;
                end
                if (wrap) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                cnt_d = cnt_step;
                // Leave at the stop sample so a following start bit is seen on time.
                if (sample) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    serr_d  = !RX_IN;
                    perr_d  = par_bad_q;
                    if (RX_IN && !par_bad_q) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            par_bad_q <= 1'b0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            serr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            par_bad_q <= par_bad_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            serr_q    <= serr_d;
        end
    end

    assign P_DATA_OUT     = data_q;
    assign DATA_VALID_OUT = valid_q;
    assign PAR_ERR        = perr_q;
    assign STP_ERR        = serr_q;
    assign RX_BUSY        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: one instance at PRESCALE=1 and one at PRESCALE=8, with
// expected output events queued per frame and matched against the pulses the receiver emits.
module tb_uart_rx_deserializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx1, rx8, par_en, par_typ;
    logic [7:0] data1, data8;
    logic       valid1, perr1, serr1, busy1;
    logic       valid8, perr8, serr8, busy8;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_deserializer #(.DATA_WIDTH(8), .PRESCALE(1)) u_dut1 (
        .clk            (clk),
        .reset          (reset),
        .RX_IN          (rx1),
        .PAR_EN         (par_en),
        .PAR_TYP        (par_typ),
        .P_DATA_OUT     (data1),
        .DATA_VALID_OUT (valid1),
        .PAR_ERR        (perr1),
        .STP_ERR        (serr1),
        .RX_BUSY        (busy1)
    );

    uart_rx_deserializer #(.DATA_WIDTH(8), .PRESCALE(8)) u_dut8 (
        .clk            (clk),
        .reset          (reset),
        .RX_IN          (rx8),
        .PAR_EN         (par_en),
        .PAR_TYP        (par_typ),
        .P_DATA_OUT     (data8),
        .DATA_VALID_OUT (valid8),
        .PAR_ERR        (perr8),
        .STP_ERR        (serr8),
        .RX_BUSY        (busy8)
    );

    typedef struct {
        logic [2:0] flags;  // {valid, par_err, stp_err}
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t       q1[$];
    exp_t       q8[$];
    logic [7:0] last1 = 8'h00;
    logic [7:0] last8 = 8'h00;
    int         n_checks = 0;
    int         n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    always @(negedge clk) begin : mon1
        exp_t e;
        if (reset && (valid1 || perr1 || serr1)) begin
            if (q1.size() == 0) begin
                check("p1_spurious", 32'({valid1, perr1, serr1}), 32'd0);
            end else begin
                e = q1.pop_front();
                check("p1_flags", 32'({valid1, perr1, serr1}), 32'(e.flags));
                check("p1_cycle", 32'(cyc), 32'(e.cyc));
                check("p1_data", 32'(data1), 32'(e.data));
            end
        end
    end

    always @(negedge clk) begin : mon8
        exp_t e;
        if (reset && (valid8 || perr8 || serr8)) begin
            if (q8.size() == 0) begin
                check("p8_spurious", 32'({valid8, perr8, serr8}), 32'd0);
            end else begin
                e = q8.pop_front();
                check("p8_flags", 32'({valid8, perr8, serr8}), 32'(e.flags));
                check("p8_cycle", 32'(cyc), 32'(e.cyc));
                check("p8_data", 32'(data8), 32'(e.data));
            end
        end
    end

    task automatic drive(input int p, input logic b);
        if (p == 1) rx1 = b;
        else rx8 = b;
    endtask

    task automatic idle(input int n);
        rx1 = 1'b1;
        rx8 = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; drives one frame and queues the expected event unless aborted.
    task automatic send_frame(input int p, input logic [7:0] d, input logic pen, input logic ptyp,
                              input logic pbit, input logic stop, input int abort_at);
        logic [10:0] bits;
        logic        perr, valid;
        int          n, e0;
        exp_t        e;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        if (pen) begin
            bits[9]  = pbit;
            bits[10] = stop;
            n = 11;
        end else begin
            bits[9] = stop;
            n = 10;
        end
        par_en  = pen;
        par_typ = ptyp;
        e0 = cyc + 1;
        if (abort_at < 0) begin
            perr  = pen && (pbit != ((^d) ^ ptyp));
            valid = stop && !perr;
            e.flags = {valid, perr, !stop};
            e.cyc   = e0 + (pen ? 10 : 9) * p + p / 2;
            if (p == 1) begin
                e.data = valid ? d : last1;
                if (valid) last1 = d;
                q1.push_back(e);
            end else begin
                e.data = valid ? d : last8;
                if (valid) last8 = d;
                q8.push_back(e);
            end
        end
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                check("abort_busy", 32'(p == 1 ? busy1 : busy8), 32'd1);
                reset = 1'b0;
                drive(p, 1'b1);
                @(negedge clk);
                check("abort_data", 32'(data8), 32'd0);
                check("abort_valid", 32'(valid8), 32'd0);
                check("abort_perr", 32'(perr8), 32'd0);
                check("abort_serr", 32'(serr8), 32'd0);
                check("abort_busy_low", 32'(busy8), 32'd0);
                check("abort_data1", 32'(data1), 32'd0);
                last1 = 8'h00;
                last8 = 8'h00;
                reset = 1'b1;
                return;
            end
            drive(p, bits[i]);
            // Mid-frame config changes must not affect the frame in flight.
            if (i == 1) begin
                par_en  = ~pen;
                par_typ = ~ptyp;
            end
            repeat (p) @(negedge clk);
        end
        drive(p, 1'b1);
    endtask

    initial begin
        int e0;
        reset   = 1'b0;
        rx1     = 1'b1;
        rx8     = 1'b1;
        par_en  = 1'b0;
        par_typ = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data1", 32'(data1), 32'd0);
        check("rst_valid1", 32'(valid1), 32'd0);
        check("rst_perr1", 32'(perr1), 32'd0);
        check("rst_serr1", 32'(serr1), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        check("rst_data8", 32'(data8), 32'd0);
        check("rst_valid8", 32'(valid8), 32'd0);
        check("rst_perr8", 32'(perr8), 32'd0);
        check("rst_serr8", 32'(serr8), 32'd0);
        check("rst_busy8", 32'(busy8), 32'd0);
        reset = 1'b1;
        idle(3);

        // Clean frame at native rate, no parity.
        send_frame(1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        idle(5);

        // Even parity at PRESCALE=8: good, bad (same byte), bad (different byte, must hold 0x01).
        send_frame(8, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        idle(4);
        send_frame(8, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        idle(4);
        send_frame(8, 8'hC3, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        idle(4);

        // Odd parity: good frame, then a stop-bit error.
        send_frame(8, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, -1);
        idle(4);
        send_frame(8, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, -1);
        idle(30);

        // False start: line low for two clocks only.
        @(negedge clk);
        rx8 = 1'b0;
        e0 = cyc + 1;
        repeat (2) @(negedge clk);
        rx8 = 1'b1;
        check("fs_busy_high", 32'(busy8), 32'd1);
        repeat (3) @(negedge clk);
        check("fs_cycle", 32'(cyc), 32'(e0 + 4));
        check("fs_busy_low", 32'(busy8), 32'd0);
        check("fs_data_hold", 32'(data8), 32'h3C);
        idle(10);

        // Back-to-back frames at native rate with parity.
        send_frame(1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        send_frame(1, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        idle(5);

        // Reset during data bit 4, then a clean frame.
        send_frame(8, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1, 5);
        idle(4);
        send_frame(8, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        idle(20);

        check("sb1_empty", 32'(q1.size()), 32'd0);
        check("sb8_empty", 32'(q8.size()), 32'd0);
        check("final_data8", 32'(data8), 32'h7E);
        check("final_busy8", 32'(busy8), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
